// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// Shares one byte-wide RAM port between instruction fetch and the MEM stage, sequencing
// 1/2/4-byte accesses little-endian. Define ARB_RR_EN for round-robin tie-breaking.
//  state  | meaning
//  IDLE   | no access in flight; grant decided here
//  IF_RD  | fetch word being read
//  MEM_RD | load being read
//  MEM_WR | store being written
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              flush_i,
  output logic              if_ack_o,
  output logic [31:0]       if_inst_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_ack_o,
  output logic [31:0]       mem_rdata_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i,
  output logic              stall_if_o,
  output logic              stall_mem_o
);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  localparam logic [2:0] LAT  = 3'(RD_LAT);
  localparam logic [2:0] LAT1 = 3'(RD_LAT + 1);

  state_t            state, state_nx;
  logic [2:0]        cnt, cnt_nx;
  logic [2:0]        nbytes, nbytes_nx;
  logic [ADDR_W-1:0] base, base_nx;
  logic [31:0]       wdata, wdata_nx;
  logic [31:0]       rbuf, rbuf_nx;
  logic              last_if, last_if_nx;
  logic [ADDR_W-1:0] ram_a_nx;
  logic              ram_wr_nx;
  logic [7:0]        ram_dout_nx;
  logic              if_ack_nx, mem_ack_nx;
  logic [31:0]       if_inst_nx, mem_rdata_nx;
  logic              if_ok, mem_ok, pick_mem;
  logic [2:0]        mem_n;
  logic [2:0]        rd_k;
  logic              rd_hit;
  logic [ADDR_W-1:0] cnt_ext;

  // A requester is ignored in its own ack cycle, guaranteeing an idle cycle between accesses
  assign if_ok   = if_req_i & ~if_ack_o & ~flush_i;
  assign mem_ok  = mem_req_i & ~mem_ack_o;
  assign mem_n   = (mem_size_i == 2'd0) ? 3'd1 : (mem_size_i == 2'd1) ? 3'd2 : 3'd4;
  assign cnt_ext = {{(ADDR_W-3){1'b0}}, cnt};

`ifdef ARB_RR_EN
  assign pick_mem = mem_ok & (~if_ok | last_if);
`else
  assign pick_mem = mem_ok;
`endif

  assign stall_if_o  = if_req_i & ~if_ack_o;
  assign stall_mem_o = mem_req_i & ~mem_ack_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      nbytes      <= '0;
      base        <= '0;
      wdata       <= '0;
      rbuf        <= '0;
      last_if     <= 1'b1;
      ram_a_o     <= '0;
      ram_wr_o    <= 1'b0;
      ram_dout_o  <= '0;
      if_ack_o    <= 1'b0;
      mem_ack_o   <= 1'b0;
      if_inst_o   <= '0;
      mem_rdata_o <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      nbytes      <= nbytes_nx;
      base        <= base_nx;
      wdata       <= wdata_nx;
      rbuf        <= rbuf_nx;
      last_if     <= last_if_nx;
      ram_a_o     <= ram_a_nx;
      ram_wr_o    <= ram_wr_nx;
      ram_dout_o  <= ram_dout_nx;
      if_ack_o    <= if_ack_nx;
      mem_ack_o   <= mem_ack_nx;
      if_inst_o   <= if_inst_nx;
      mem_rdata_o <= mem_rdata_nx;
    end
  end

  // cnt = cycles since grant; byte k is captured RD_LAT cycles after its address was issued
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    nbytes_nx    = nbytes;
    base_nx      = base;
    wdata_nx     = wdata;
    rbuf_nx      = rbuf;
    last_if_nx   = last_if;
    ram_a_nx     = '0;
    ram_wr_nx    = 1'b0;
    ram_dout_nx  = '0;
    if_ack_nx    = 1'b0;
    mem_ack_nx   = 1'b0;
    if_inst_nx   = if_inst_o;
    mem_rdata_nx = mem_rdata_o;
    rd_k         = cnt - LAT1;
    rd_hit       = ((state == IF_RD) || (state == MEM_RD)) && (cnt >= LAT1) && (rd_k < nbytes);
    if (rd_hit)
      rbuf_nx[{rd_k[1:0], 3'b000} +: 8] = ram_din_i;
    case (state)
      IDLE: begin
        if (mem_ok || if_ok) begin
          base_nx   = pick_mem ? mem_addr_i : if_addr_i;
          nbytes_nx = pick_mem ? mem_n : 3'd4;
          wdata_nx  = mem_wdata_i;
          rbuf_nx   = '0;
          cnt_nx    = 3'd1;
          ram_a_nx  = base_nx;
          if (mem_ok && if_ok)
            last_if_nx = ~pick_mem;
          if (pick_mem && mem_we_i) begin
            state_nx    = MEM_WR;
            ram_wr_nx   = 1'b1;
            ram_dout_nx = mem_wdata_i[7:0];
          end else begin
            state_nx = pick_mem ? MEM_RD : IF_RD;
          end
        end
      end
      IF_RD, MEM_RD: begin
        if ((state == IF_RD) && flush_i) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 3'd1;
          if (cnt < nbytes)
            ram_a_nx = base + cnt_ext;
          if (cnt == nbytes + LAT) begin
            state_nx = IDLE;
            if (state == IF_RD) begin
              if_ack_nx  = 1'b1;
              if_inst_nx = rbuf_nx;
            end else begin
              mem_ack_nx   = 1'b1;
              mem_rdata_nx = rbuf_nx;
            end
          end
        end
      end
      MEM_WR: begin
        if (cnt < nbytes) begin
          ram_a_nx    = base + cnt_ext;
          ram_wr_nx   = 1'b1;
          ram_dout_nx = wdata[{cnt[1:0], 3'b000} +: 8];
          cnt_nx      = cnt + 3'd1;
        end else begin
          state_nx   = IDLE;
          mem_ack_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_arbiter (RD_LAT=1): directed scenarios plus randomized single-requester
// traffic, checked against a byte-addressed memory model and transaction timing rules.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, flush_i, if_ack_o;
  logic [31:0] if_addr_i, if_inst_o;
  logic        mem_req_i, mem_we_i, mem_ack_o;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic [31:0] ram_a_o;
  logic        ram_wr_o;
  logic [7:0]  ram_dout_o, ram_din_i;
  logic        stall_if_o, stall_mem_o;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .flush_i(flush_i),
    .if_ack_o(if_ack_o), .if_inst_o(if_inst_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_ack_o(mem_ack_o), .mem_rdata_o(mem_rdata_o),
    .ram_a_o(ram_a_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i),
    .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o)
  );

  // RAM attached to the DUT port: one-cycle read latency, indexed by the low 16 address bits
  logic [7:0]  env_mem [65536];
  bit          env_wr  [65536];
  logic        pre_en = 1'b0;
  logic [15:0] pre_a  = '0;
  logic [7:0]  pre_d  = '0;

  // Expected memory contents, updated only from the bench's own view of each transaction
  logic [7:0]  ref_mem [logic [31:0]];

  int n_cmp = 0;
  int n_bad = 0;
`ifdef ARB_RR_EN
  logic exp_last_if = 1'b1;
`endif

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  always @(posedge clk) begin
    if (pre_en) begin
      env_mem[pre_a] <= pre_d;
      env_wr[pre_a]  <= 1'b1;
    end else if (ram_wr_o) begin
      env_mem[ram_a_o[15:0]] <= ram_dout_o;
      env_wr[ram_a_o[15:0]]  <= 1'b1;
    end
    ram_din_i <= env_wr[ram_a_o[15:0]] ? env_mem[ram_a_o[15:0]] : dflt(ram_a_o);
  end

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_val(input logic [31:0] a, input int n);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_rd(32'(a + k));
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload_word(input logic [31:0] a, input logic [31:0] w);
    logic [31:0] ak;
    for (int k = 0; k < 4; k++) begin
      ak = 32'(a + k);
      step();
      pre_en = 1'b1;
      pre_a  = ak[15:0];
      pre_d  = w[8*k +: 8];
      ref_mem[ak] = w[8*k +: 8];
    end
    step();
    pre_en = 1'b0;
  endtask

  // d=1 raises flush_i in the request cycle, which must delay the grant by one cycle
  task automatic fetch(input logic [31:0] a, input int d);
    int c;
    logic got;
    logic [31:0] expd;
    expd = ref_val(a, 4);
    step();
    if_req_i = 1'b1; if_addr_i = a; flush_i = (d != 0);
    c = 0; got = 1'b0;
    while (!got && c <= 14) begin
      @(negedge clk);
      if (c == 0) chk("if_stall", stall_if_o, 1);
      if (c >= 1 + d && c <= 4 + d) chk("if_ram_a", ram_a_o, 32'(a + c - 1 - d));
      chk("if_no_wr", ram_wr_o, 0);
      if (if_ack_o) got = 1'b1;
      else begin
        c++;
        if (c == 1) begin step(); flush_i = 1'b0; end
      end
    end
    chk("if_ack_seen", got, 1);
    chk("if_ack_cycle", c, 6 + d);
    chk("if_inst", if_inst_o, expd);
    step();
    if_req_i = 1'b0;
    @(negedge clk);
    chk("if_ack_pulse", if_ack_o, 0);
  endtask

  task automatic mem_access(input logic we, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd);
    int n, c;
    logic got;
    logic [31:0] expd;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    expd = ref_val(a, n);
    step();
    mem_req_i = 1'b1; mem_we_i = we; mem_size_i = sz; mem_addr_i = a; mem_wdata_i = wd;
    c = 0; got = 1'b0;
    while (!got && c <= 12) begin
      @(negedge clk);
      if (c == 0) chk("mem_stall", stall_mem_o, 1);
      if (c >= 1 && c <= n) begin
        chk("mem_ram_a", ram_a_o, 32'(a + c - 1));
        chk("mem_ram_wr", ram_wr_o, we);
        if (we) chk("mem_wr_byte", ram_dout_o, wd[8*(c-1) +: 8]);
      end else if (c > n) begin
        chk("mem_wr_tail", ram_wr_o, 0);
      end
      if (mem_ack_o) got = 1'b1;
      else c++;
    end
    chk("mem_ack_seen", got, 1);
    chk("mem_ack_cycle", c, we ? n + 1 : n + 2);
    if (!we) chk("mem_rdata", mem_rdata_o, expd);
    if (we) for (int k = 0; k < n; k++) ref_mem[32'(a + k)] = wd[8*k +: 8];
    step();
    mem_req_i = 1'b0; mem_we_i = 1'b0;
    @(negedge clk);
    chk("mem_ack_pulse", mem_ack_o, 0);
  endtask

  // Fetch and load-word raised in the same cycle
  task automatic tie_access(input logic [31:0] ia, input logic [31:0] ma);
    int mem_ack_c, if_ack_c, if_first_c, mem_first_c;
    int f_first, f_ack, s_first, s_ack;
    logic mem_first, wr_seen;
    logic [31:0] ei, em;
    ei = ref_val(ia, 4);
    em = ref_val(ma, 4);
`ifdef ARB_RR_EN
    mem_first   = exp_last_if;
    exp_last_if = ~exp_last_if;
`else
    mem_first = 1'b1;
`endif
    step();
    if_req_i = 1'b1; if_addr_i = ia; flush_i = 1'b0;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'd2; mem_addr_i = ma;
    mem_ack_c = -1; if_ack_c = -1; if_first_c = -1; mem_first_c = -1; wr_seen = 1'b0;
    for (int c = 0; c <= 20 && (mem_ack_c < 0 || if_ack_c < 0); c++) begin
      @(negedge clk);
      if (c == 0) chk("tie_stall_if", stall_if_o, 1);
      if (ram_wr_o) wr_seen = 1'b1;
      if (ram_a_o == ia && if_first_c < 0) if_first_c = c;
      if (ram_a_o == ma && mem_first_c < 0) mem_first_c = c;
      if (mem_ack_o) begin
        mem_ack_c = c;
        chk("tie_mem_rdata", mem_rdata_o, em);
        step(); mem_req_i = 1'b0;
      end else if (if_ack_o) begin
        if_ack_c = c;
        chk("tie_if_inst", if_inst_o, ei);
        step(); if_req_i = 1'b0;
      end
    end
    step();
    if_req_i = 1'b0; mem_req_i = 1'b0;
    f_first = mem_first ? mem_first_c : if_first_c;
    f_ack   = mem_first ? mem_ack_c   : if_ack_c;
    s_first = mem_first ? if_first_c  : mem_first_c;
    s_ack   = mem_first ? if_ack_c    : mem_ack_c;
    chk("tie_no_wr", wr_seen, 0);
    chk("tie_first_addr", f_first, 1);
    chk("tie_first_ack", f_ack, 6);
    chk("tie_second_after_ack", (s_first > f_ack), 1);
    chk("tie_second_ack", s_ack, s_first + 5);
  endtask

  initial begin
    int cyc;
    logic got;
    logic [31:0] ra;
    int op;
    rst = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0; flush_i = 1'b0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_size_i = '0; mem_addr_i = '0; mem_wdata_i = '0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_ram_a", ram_a_o, 0);
    chk("rst_ram_wr", ram_wr_o, 0);
    chk("rst_ram_dout", ram_dout_o, 0);
    chk("rst_if_ack", if_ack_o, 0);
    chk("rst_mem_ack", mem_ack_o, 0);
    chk("rst_if_inst", if_inst_o, 0);
    chk("rst_mem_rdata", mem_rdata_o, 0);
    step();
    rst = 1'b0;

    preload_word(32'h0000_1000, 32'h0000_0513);
    preload_word(32'h0000_2000, 32'h0011_22B7);
    preload_word(32'h0000_4000, 32'h1234_5678);

    // Plain fetch, then fetch with flush_i in the request cycle
    fetch(32'h0000_1000, 0);
    chk("t1_inst_word", if_inst_o, 32'h0000_0513);
    fetch(32'h0000_1000, 1);

    // Simultaneous requests, twice
    tie_access(32'h0000_4000, 32'h0000_2000);
    tie_access(32'h0000_4000, 32'h0000_2000);

    // Misaligned half store then byte/half loads
    mem_access(1'b1, 2'd1, 32'h0000_0003, 32'h0000_ABCD);
    mem_access(1'b0, 2'd0, 32'h0000_0003, 32'h0);
    chk("t3_byte_load", mem_rdata_o, 32'h0000_00CD);
    mem_access(1'b0, 2'd1, 32'h0000_0003, 32'h0);
    chk("t3_half_load", mem_rdata_o, 32'h0000_ABCD);
    chk("t3_rdata_hold", mem_rdata_o, 32'h0000_ABCD);

    // Flush while the second byte of a fetch is on the bus, redirect to 0x2000
    step();
    if_req_i = 1'b1; if_addr_i = 32'h0000_1000;
    @(negedge clk); chk("fl_ack_g0", if_ack_o, 0);
    step(); @(negedge clk); chk("fl_a0", ram_a_o, 32'h0000_1000);
    step(); flush_i = 1'b1; if_addr_i = 32'h0000_2000;
    @(negedge clk); chk("fl_a1", ram_a_o, 32'h0000_1001);
    step(); flush_i = 1'b0;
    @(negedge clk); chk("fl_idle_a", ram_a_o, 0); chk("fl_no_ack", if_ack_o, 0);
    cyc = 3; got = 1'b0;
    while (!got && cyc < 16) begin
      step(); @(negedge clk); cyc++;
      if (cyc == 4) chk("fl_new_a", ram_a_o, 32'h0000_2000);
      if (if_ack_o) got = 1'b1;
    end
    chk("fl_ack_cycle", cyc, 9);
    chk("fl_inst", if_inst_o, 32'h0011_22B7);
    step(); if_req_i = 1'b0;

    // Word load across the top of the address space
    mem_access(1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0);

    // Randomized single-requester traffic near the bottom and top of memory
    for (int i = 0; i < 48; i++) begin
      ra = (($urandom_range(0, 1) == 0) ? 32'h0000_0100 : 32'hFFFF_FFF0) + 32'($urandom_range(0, 31));
      op = int'($urandom_range(0, 2));
      if (op == 0) fetch(ra, 0);
      else mem_access(op == 1, 2'($urandom_range(0, 3)), ra, $urandom);
    end

    // Reset during the second byte of a word store
    step();
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_size_i = 2'd2;
    mem_addr_i = 32'h0000_3000; mem_wdata_i = 32'hDEAD_BEEF;
    step(); @(negedge clk);
    chk("rs_a0", ram_a_o, 32'h0000_3000); chk("rs_wr0", ram_wr_o, 1);
    step(); rst = 1'b1;
    @(negedge clk);
    chk("rs_a1", ram_a_o, 32'h0000_3001); chk("rs_d1", ram_dout_o, 8'hBE);
    step(); rst = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0;
    @(negedge clk);
    chk("rs_ram_a", ram_a_o, 0);
    chk("rs_ram_wr", ram_wr_o, 0);
    chk("rs_ram_dout", ram_dout_o, 0);
    chk("rs_if_ack", if_ack_o, 0);
    chk("rs_mem_ack", mem_ack_o, 0);
    chk("rs_if_inst", if_inst_o, 0);
    chk("rs_mem_rdata", mem_rdata_o, 0);
    for (int i = 0; i < 8; i++) begin
      step(); @(negedge clk);
      chk("rs_no_ack", mem_ack_o, 0);
      chk("rs_no_wr", ram_wr_o, 0);
    end
    mem_access(1'b0, 2'd2, 32'h0000_1000, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
